// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-bus controller.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        MEM_BUS_IDLE,
        MEM_BUS_REQ,
        MEM_BUS_WAIT,
        MEM_BUS_DONE
    } mem_bus_state_e;

    localparam logic [3:0] SZ_B = 4'b0001;
    localparam logic [3:0] SZ_H = 4'b0010;
    localparam logic [3:0] SZ_W = 4'b0100;
    localparam logic [3:0] SZ_D = 4'b1000;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Unshifted byte-lane pattern for an access size; an empty mask selects no lanes.
    function automatic logic [7:0] size_strb(input logic [3:0] mask);
        case (mask)
            SZ_D:    return 8'hFF;
            SZ_W:    return 8'h0F;
            SZ_H:    return 8'h03;
            SZ_B:    return 8'h01;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] offset, input logic [3:0] mask);
        case (mask)
            SZ_D:    return offset != 3'd0;
            SZ_W:    return offset[1:0] != 2'd0;
            SZ_H:    return offset[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store data/strobes shifted up to the bus lanes, load data shifted down and masked to size.
module mem_lane_align
    import mem_bus_ctrl_pkg::*;
(
    input  logic [2:0]  offset,
    input  logic [3:0]  mask,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  wstrb,
    output logic [63:0] wdata_lane,
    output logic [63:0] rdata_right
);

    logic [7:0]  base;
    logic [63:0] size_bits;

    // Shifting within fixed widths drops lanes past the 8-byte word, which truncates boundary-crossing accesses.
    always_comb begin
        base       = size_strb(mask);
        wstrb      = base << offset;
        wdata_lane = wdata << {offset, 3'b000};
        size_bits  = '0;
        for (int i = 0; i < 8; i++) begin
            size_bits[i*8 +: 8] = {8{base[i]}};
        end
        rdata_right = (rdata >> {offset, 3'b000}) & size_bits;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage load/store to valid/ready data-bus controller; stalls the pipe while an access is in flight.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses skip the bus and pulse MisalignOut.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IsLoadIn,
    input  logic              IsStoreIn,
    input  logic [ADDR_W-1:0] RaddrIn,
    input  logic [ADDR_W-1:0] WaddrIn,
    input  logic [DATA_W-1:0] WdataIn,
    input  logic [3:0]        WmaskIn,
    input  logic              PipeHoldIn,
    output logic              StallOut,
    output logic [DATA_W-1:0] LoadDataOut,
    output logic              BusErrOut,
    output logic              BusReqValid,
    input  logic              BusReqReady,
    output logic              BusReqWe,
    output logic [ADDR_W-1:0] BusReqAddr,
    output logic [DATA_W-1:0] BusReqWdata,
    output logic [7:0]        BusReqWstrb,
    input  logic              BusRespValid,
    input  logic [DATA_W-1:0] BusRespData,
    input  logic              BusRespErr
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              MisalignOut
`endif
);

    localparam int TW = $clog2(RESP_TIMEOUT + 1);

    mem_bus_state_e    state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        mask_q;
    logic              we_q;
    logic [DATA_W-1:0] ldata_q;
    logic              err_q;
    logic              trap_q;
    logic [TW-1:0]     timer_q;

    logic              req_new, new_we, take_resp, timeout, trap, req_active;
    logic [ADDR_W-1:0] new_addr;
    logic [7:0]        lane_strb;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;

    // Both opcode flags together decode as a load.
    assign req_new    = IsLoadIn || IsStoreIn;
    assign new_we     = IsStoreIn && !IsLoadIn;
    assign new_addr   = new_we ? WaddrIn : RaddrIn;
    assign req_active = (state_q == MEM_BUS_REQ);

    mem_lane_align u_align (
        .offset      (addr_q[2:0]),
        .mask        (mask_q),
        .wdata       (wdata_q),
        .rdata       (BusRespData),
        .wstrb       (lane_strb),
        .wdata_lane  (lane_wdata),
        .rdata_right (lane_rdata)
    );

    always_comb begin
        state_d   = state_q;
        take_resp = 1'b0;
        timeout   = 1'b0;
        trap      = 1'b0;
        StallOut  = 1'b0;
        unique case (state_q)
            MEM_BUS_IDLE: begin
                StallOut = req_new;
                if (req_new) begin
`ifdef MEM_MISALIGN_TRAP_EN
                    trap = misaligned(new_addr[2:0], WmaskIn);
`endif
                    state_d = trap ? MEM_BUS_DONE : MEM_BUS_REQ;
                end
            end
            MEM_BUS_REQ: begin
                StallOut = 1'b1;
                if (BusReqReady) begin
                    take_resp = BusRespValid;
                    state_d   = BusRespValid ? MEM_BUS_DONE : MEM_BUS_WAIT;
                end
            end
            MEM_BUS_WAIT: begin
                StallOut = 1'b1;
                if (BusRespValid) begin
                    take_resp = 1'b1;
                    state_d   = MEM_BUS_DONE;
                end else if (timer_q == TW'(RESP_TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = MEM_BUS_DONE;
                end
            end
            MEM_BUS_DONE: begin
                if (!PipeHoldIn) state_d = MEM_BUS_IDLE;
            end
            default: state_d = MEM_BUS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MEM_BUS_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
            ldata_q <= '0;
            err_q   <= 1'b0;
            trap_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            trap_q  <= 1'b0;
            if (state_q == MEM_BUS_IDLE && req_new) begin
                addr_q  <= new_addr;
                wdata_q <= WdataIn;
                mask_q  <= WmaskIn;
                we_q    <= new_we;
                if (trap) begin
                    ldata_q <= '0;
                    trap_q  <= 1'b1;
                end
            end
            if (req_active) timer_q <= '0;
            else if (state_q == MEM_BUS_WAIT) timer_q <= timer_q + 1'b1;
            // Stores keep the previously returned load data; only their error bit matters.
            if (take_resp) begin
                if (!we_q) ldata_q <= lane_rdata;
                err_q <= BusRespErr;
            end
            if (timeout) begin
                ldata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign BusReqValid = req_active;
    assign BusReqWe    = req_active && we_q;
    assign BusReqAddr  = req_active ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
    assign BusReqWdata = (req_active && we_q) ? lane_wdata : '0;
    assign BusReqWstrb = (req_active && we_q) ? lane_strb : 8'h00;
    assign LoadDataOut = ldata_q;
    assign BusErrOut   = err_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign MisalignOut = trap_q;
`else
    logic unused_trap;
    assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed + random bench for mem_bus_ctrl with a scoreboard of expected bus requests and load results.
module tb_mem_bus_ctrl;

    localparam int TO = 255;

    logic        clk, rst_n;
    logic        IsLoadIn, IsStoreIn, PipeHoldIn;
    logic [63:0] RaddrIn, WaddrIn, WdataIn;
    logic [3:0]  WmaskIn;
    logic        StallOut, BusErrOut, BusReqValid, BusReqReady, BusReqWe;
    logic [63:0] LoadDataOut, BusReqAddr, BusReqWdata, BusRespData;
    logic [7:0]  BusReqWstrb;
    logic        BusRespValid, BusRespErr;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        MisalignOut;
`endif

    mem_bus_ctrl #(.ADDR_W(64), .DATA_W(64), .RESP_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IsLoadIn     (IsLoadIn),
        .IsStoreIn    (IsStoreIn),
        .RaddrIn      (RaddrIn),
        .WaddrIn      (WaddrIn),
        .WdataIn      (WdataIn),
        .WmaskIn      (WmaskIn),
        .PipeHoldIn   (PipeHoldIn),
        .StallOut     (StallOut),
        .LoadDataOut  (LoadDataOut),
        .BusErrOut    (BusErrOut),
        .BusReqValid  (BusReqValid),
        .BusReqReady  (BusReqReady),
        .BusReqWe     (BusReqWe),
        .BusReqAddr   (BusReqAddr),
        .BusReqWdata  (BusReqWdata),
        .BusReqWstrb  (BusReqWstrb),
        .BusRespValid (BusRespValid),
        .BusRespData  (BusRespData),
        .BusRespErr   (BusRespErr)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .MisalignOut  (MisalignOut)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [63:0] ldata;
        logic        err;
        int          stalls;
        logic        trap;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] last_ld = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic int m_size(input logic [3:0] m);
        case (m)
            4'b1000: return 8;
            4'b0100: return 4;
            4'b0010: return 2;
            4'b0001: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] m_strb(input logic [2:0] off, input logic [3:0] m);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = (b >= int'(off)) && (b < int'(off) + m_size(m));
        return r;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [2:0] off, input logic [63:0] wd);
        logic [63:0] r = '0;
        for (int b = 0; b < 8; b++)
            if (b >= int'(off)) r[b*8 +: 8] = wd[(b - int'(off))*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] m_rdata(input logic [2:0] off, input logic [3:0] m, input logic [63:0] rd);
        logic [63:0] r = '0;
        for (int i = 0; i < m_size(m); i++)
            if (int'(off) + i < 8) r[i*8 +: 8] = rd[(int'(off) + i)*8 +: 8];
        return r;
    endfunction

    function automatic logic m_misaligned(input logic [2:0] off, input logic [3:0] m);
        int n = m_size(m);
        return (n > 1) && ((int'(off) % n) != 0);
    endfunction

    // resp_wait: 0 = response with the accepting Ready, k = k cycles later, -1 = never (timeout).
    task automatic run_txn(input logic ld, input logic st, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [3:0] mask, input int rdy_wait, input int resp_wait,
                           input logic [63:0] rd, input logic rerr, input int hold);
        exp_t        e;
        int          k_req, k_wait, phase, stalls;
        logic        done, rdy, rsp;
        logic [63:0] held;
        e.we     = st && !ld;
        e.addr   = {addr[63:3], 3'b000};
        e.strb   = e.we ? m_strb(addr[2:0], mask) : 8'h00;
        e.wdata  = e.we ? m_wdata(addr[2:0], wd) : 64'h0;
        e.trap   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        e.trap   = m_misaligned(addr[2:0], mask);
`endif
        e.err    = !e.trap && ((resp_wait < 0) || rerr);
        if (e.trap || resp_wait < 0) e.ldata = '0;
        else if (e.we)               e.ldata = last_ld;
        else                         e.ldata = m_rdata(addr[2:0], mask, rd);
        e.stalls = e.trap ? 1 : 2 + rdy_wait + ((resp_wait < 0) ? TO : resp_wait);
        last_ld  = e.ldata;
        sb_q.push_back(e);

        @(posedge clk); #1;
        IsLoadIn  = ld;
        IsStoreIn = st;
        RaddrIn   = e.we ? 64'h0BAD_0000_0000_0007 : addr;
        WaddrIn   = e.we ? addr : 64'h0BAD_0000_0000_0005;
        WdataIn   = wd;
        WmaskIn   = mask;
        #1;
        check("stall_issue", {63'b0, StallOut}, 64'd1);
        stalls = 1; phase = 0; k_req = 0; k_wait = 0; done = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(posedge clk); #1;
            rdy = 1'b0; rsp = 1'b0;
            if (phase == 0) begin
                rdy = (k_req >= rdy_wait);
                rsp = rdy && (resp_wait == 0);
            end else if (phase == 1) begin
                rsp = (resp_wait > 0) && (k_wait == resp_wait - 1);
            end
            BusReqReady  = rdy;
            BusRespValid = rsp;
            BusRespData  = rd;
            BusRespErr   = rsp && rerr;
            #1;
            if (!StallOut) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (phase == 0) begin
                    check("req_valid", {63'b0, BusReqValid}, 64'd1);
                    check("req_addr", BusReqAddr, sb_q[0].addr);
                    check("req_we", {63'b0, BusReqWe}, {63'b0, sb_q[0].we});
                    check("req_wdata", BusReqWdata, sb_q[0].wdata);
                    check("req_wstrb", {56'b0, BusReqWstrb}, {56'b0, sb_q[0].strb});
                    k_req++;
                    if (rdy) phase = rsp ? 2 : 1;
                end else begin
                    check("valid_after_hs", {63'b0, BusReqValid}, 64'd0);
                    k_wait++;
                end
            end
        end
        check("done_reached", {63'b0, done}, 64'd1);
        BusReqReady = 1'b0; BusRespValid = 1'b0; BusRespErr = 1'b0;
        PipeHoldIn  = (hold > 0);
        e = sb_q.pop_front();
        check("stall_cycles", 64'(stalls), 64'(e.stalls));
        check("load_data", LoadDataOut, e.ldata);
        check("bus_err_pulse", {63'b0, BusErrOut}, {63'b0, e.err});
        check("done_no_req", {63'b0, BusReqValid}, 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        check("misalign", {63'b0, MisalignOut}, {63'b0, e.trap});
`endif
        held = LoadDataOut;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            PipeHoldIn = (h < hold - 1);
            #1;
            check("hold_stall", {63'b0, StallOut}, 64'd0);
            check("hold_no_req", {63'b0, BusReqValid}, 64'd0);
            check("hold_ldata", LoadDataOut, held);
            check("hold_err", {63'b0, BusErrOut}, 64'd0);
        end
        @(posedge clk); #1;
        IsLoadIn = 1'b0; IsStoreIn = 1'b0; PipeHoldIn = 1'b0;
        #1;
        check("idle_stall", {63'b0, StallOut}, 64'd0);
        check("idle_no_req", {63'b0, BusReqValid}, 64'd0);
        check("idle_err", {63'b0, BusErrOut}, 64'd0);
        check("idle_ldata", LoadDataOut, held);
    endtask

    initial begin
        rst_n = 1'b0;
        IsLoadIn = 0; IsStoreIn = 0; PipeHoldIn = 0;
        RaddrIn = '0; WaddrIn = '0; WdataIn = '0; WmaskIn = '0;
        BusReqReady = 0; BusRespValid = 0; BusRespData = '0; BusRespErr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {63'b0, StallOut}, 64'd0);
        check("rst_valid", {63'b0, BusReqValid}, 64'd0);
        check("rst_ldata", LoadDataOut, 64'd0);
        check("rst_err", {63'b0, BusErrOut}, 64'd0);
        check("rst_addr", BusReqAddr, 64'd0);
        rst_n = 1'b1;

        run_txn(1, 0, 64'h8000_0008, 64'h0, 4'b1000, 0, 0, 64'h1122_3344_5566_7788, 0, 0);
        run_txn(1, 0, 64'h8000_0008, 64'h0, 4'b1000, 0, 1, 64'h0102_0304_0506_0708, 0, 0);
        run_txn(0, 1, 64'h8000_0013, 64'hAB, 4'b0001, 0, 1, 64'h0, 0, 0);
        run_txn(1, 0, 64'h8000_0004, 64'h0, 4'b0100, 0, 1, 64'hDEAD_BEEF_0123_4567, 0, 3);
        run_txn(1, 0, 64'h8000_0018, 64'h0, 4'b1000, 5, -1, 64'h0, 0, 0);
        run_txn(0, 1, 64'h8000_0020, 64'hCAFE_F00D, 4'b0100, 1, 2, 64'h0, 1, 1);
        run_txn(0, 1, 64'h8000_0035, 64'h1122_3344_5566_7788, 4'b1000, 0, 0, 64'h0, 0, 0);
        run_txn(1, 0, 64'h8000_0047, 64'h0, 4'b0010, 0, 0, 64'hA5B6_C7D8_E9FA_0B1C, 0, 0);
        run_txn(0, 1, 64'h8000_0048, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0000, 0, 0, 64'h0, 0, 0);
        run_txn(1, 1, 64'h8000_0051, 64'h7777, 4'b0001, 0, 1, 64'h0011_2233_4455_6677, 0, 0);
        run_txn(1, 0, 64'h8000_0062, 64'h0, 4'b0100, 0, 0, 64'h8899_AABB_CCDD_EEFF, 0, 0);

        // Reset while waiting for a response that never comes.
        @(posedge clk); #1;
        IsLoadIn = 1; RaddrIn = 64'h8000_0070; WmaskIn = 4'b1000;
        @(posedge clk); #1;
        BusReqReady = 1;
        repeat (4) begin @(posedge clk); #1; BusReqReady = 0; end
        #2;
        rst_n = 1'b0; IsLoadIn = 0;
        #1;
        check("mid_rst_stall", {63'b0, StallOut}, 64'd0);
        check("mid_rst_valid", {63'b0, BusReqValid}, 64'd0);
        check("mid_rst_ldata", LoadDataOut, 64'd0);
        check("mid_rst_addr", BusReqAddr, 64'd0);
        check("mid_rst_err", {63'b0, BusErrOut}, 64'd0);
        BusRespValid = 1; BusRespData = 64'hFEED_FACE_FEED_FACE; BusRespErr = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        BusRespValid = 0; BusRespErr = 0;
        #1;
        check("late_resp_ldata", LoadDataOut, 64'd0);
        check("late_resp_err", {63'b0, BusErrOut}, 64'd0);
        check("late_resp_stall", {63'b0, StallOut}, 64'd0);
        sb_q.delete();
        last_ld = '0;

        for (int r = 0; r < 10; r++) begin
            logic        rl, rs, re;
            logic [3:0]  rm;
            logic [63:0] ra, rd, rw;
            rl = 1'(($urandom_range(0, 1)));
            rs = !rl;
            rm = 4'b0001 << $urandom_range(0, 3);
            ra = 64'h8000_0100 + 64'($urandom_range(0, 63));
            rd = {$urandom, $urandom};
            rw = {$urandom, $urandom};
            re = ($urandom_range(0, 7) == 0);
            run_txn(rl, rs, ra, rw, rm, $urandom_range(0, 2), $urandom_range(0, 2), rd, re,
                    $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
